// File: rtl/band_energy_meter_pkg.sv
// rtl/band_energy_meter_pkg.sv - shared constants and FSM encoding for the band energy meter
package band_energy_meter_pkg;

  localparam int NBANDS   = 8;
  localparam int SAMPLE_W = 16;
  localparam int BAND_W   = 3;
  // Width of one unsigned square: (-32768)^2 = 2^30 needs 31 bits.
  localparam int SQ_W     = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/band_energy_meter_result_buf.sv
// rtl/band_energy_meter_result_buf.sv - 8-entry result store drained as a valid/ready band stream
module band_energy_meter_result_buf
  import band_energy_meter_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_i,
  input  logic [NBANDS-1:0][OUT_W-1:0]  means_i,
  input  logic                          ready_i,
  output logic                          full_o,
  output logic                          valid_o,
  output logic [BAND_W-1:0]             band_o,
  output logic [OUT_W-1:0]              data_o
);

  logic [OUT_W-1:0]  mem_q [NBANDS];
  logic              valid_q;
  logic [BAND_W-1:0] idx_q;

  // Load a whole window of means when empty, otherwise step through bands on each accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      for (int k = 0; k < NBANDS; k++) begin
        mem_q[k] <= '0;
      end
    end else if (load_i && !valid_q) begin
      for (int k = 0; k < NBANDS; k++) begin
        mem_q[k] <= means_i[k];
      end
      valid_q <= 1'b1;
      idx_q   <= '0;
    end else if (valid_q && ready_i) begin
      // Index wraps back to 0 after band 7, ready for the next load.
      idx_q <= idx_q + 1'b1;
      if (idx_q == BAND_W'(NBANDS - 1)) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign full_o  = valid_q;
  assign valid_o = valid_q;
  assign band_o  = idx_q;
  assign data_o  = valid_q ? mem_q[idx_q] : '0;

endmodule

// File: rtl/band_energy_meter.sv
// rtl/band_energy_meter.sv - per-band windowed mean power using one time-shared squarer
module band_energy_meter
  import band_energy_meter_pkg::*;
#(
  parameter int WIN_LOG2 = 6,
  parameter int OUT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] band0,
  input  logic [SAMPLE_W-1:0] band1,
  input  logic [SAMPLE_W-1:0] band2,
  input  logic [SAMPLE_W-1:0] band3,
  input  logic [SAMPLE_W-1:0] band4,
  input  logic [SAMPLE_W-1:0] band5,
  input  logic [SAMPLE_W-1:0] band6,
  input  logic [SAMPLE_W-1:0] band7,
  input  logic                clear_flags,
  output logic                energy_valid,
  input  logic                energy_ready,
  output logic [BAND_W-1:0]   energy_band,
  output logic [OUT_W-1:0]    energy_data,
  output logic [1:0]          overrun,
  output logic                busy
);

  // A full window of maximal squares fits without overflow.
  localparam int AW = SQ_W + WIN_LOG2;

  acc_state_e          state_q;
  logic [BAND_W-1:0]   ch_q;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic [SAMPLE_W-1:0] hold_q [NBANDS];
  logic [AW-1:0]       acc_q  [NBANDS];
  logic [1:0]          overrun_q;

  logic [SAMPLE_W-1:0]          bands [NBANDS];
  logic signed [2*SAMPLE_W-1:0] prod;
  logic [AW-1:0]                acc_sum;
  logic                         last_ch;
  logic                         win_done;
  logic                         drop_sample;
  logic                         drop_window;
  logic                         buf_full;
  logic                         buf_load;
  logic [NBANDS-1:0][OUT_W-1:0] means;

  assign bands[0] = band0;
  assign bands[1] = band1;
  assign bands[2] = band2;
  assign bands[3] = band3;
  assign bands[4] = band4;
  assign bands[5] = band5;
  assign bands[6] = band6;
  assign bands[7] = band7;

  // Single squarer serves the band selected by ch_q; the signed square is never negative.
  assign prod    = $signed(hold_q[ch_q]) * $signed(hold_q[ch_q]);
  assign acc_sum = acc_q[ch_q] + AW'($unsigned(prod));

  assign last_ch     = (state_q == ST_ACC) && (ch_q == BAND_W'(NBANDS - 1));
  assign win_done    = last_ch && (&win_cnt_q);
  assign drop_sample = sample_valid && (state_q == ST_ACC);
  assign drop_window = win_done && buf_full;
  assign buf_load    = win_done && !buf_full;

  // Means use band 7's freshly summed value since it lands on the same edge as the window close.
  always_comb begin
    means = '0;
    for (int k = 0; k < NBANDS; k++) begin
      if (k == NBANDS - 1) begin
        means[k] = OUT_W'(acc_sum >> WIN_LOG2);
      end else begin
        means[k] = OUT_W'(acc_q[k] >> WIN_LOG2);
      end
    end
  end

  // Accumulate FSM: capture a sample, then square-and-add one band per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      win_cnt_q <= '0;
      for (int k = 0; k < NBANDS; k++) begin
        hold_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sample_valid) begin
            for (int k = 0; k < NBANDS; k++) begin
              hold_q[k] <= bands[k];
            end
            ch_q    <= '0;
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_q[ch_q] <= acc_sum;
          ch_q        <= ch_q + 1'b1;
          if (last_ch) begin
            state_q <= ST_IDLE;
            if (win_done) begin
              // Window closes whether or not its means were kept.
              win_cnt_q <= '0;
              for (int k = 0; k < NBANDS; k++) begin
                acc_q[k] <= '0;
              end
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun flags; a same-cycle set beats the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= '0;
    end else begin
      if (clear_flags) begin
        overrun_q <= '0;
      end
      if (drop_sample) begin
        overrun_q[0] <= 1'b1;
      end
      if (drop_window) begin
        overrun_q[1] <= 1'b1;
      end
    end
  end

  band_energy_meter_result_buf #(
    .OUT_W (OUT_W)
  ) u_result_buf (
    .clock   (clock),
    .reset   (reset),
    .load_i  (buf_load),
    .means_i (means),
    .ready_i (energy_ready),
    .full_o  (buf_full),
    .valid_o (energy_valid),
    .band_o  (energy_band),
    .data_o  (energy_data)
  );

  assign overrun = overrun_q;
  assign busy    = (state_q == ST_ACC);

endmodule

// File: tb/tb_band_energy_meter.sv
// tb/tb_band_energy_meter.sv - directed table-driven bench for band_energy_meter
module tb_band_energy_meter;

  typedef logic [7:0][15:0] bvec_t;
  typedef logic [7:0][31:0] evec_t;
  typedef struct {
    bvec_t val;
    bit    alt;
    evec_t exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic        clear_flags;
  logic        energy_ready;
  logic [15:0] band0, band1, band2, band3, band4, band5, band6, band7;
  logic        energy_valid;
  logic [2:0]  energy_band;
  logic [31:0] energy_data;
  logic [1:0]  overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit saw_valid = 0;
  logic [2:0]  q_band[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  band_energy_meter dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .band0        (band0),
    .band1        (band1),
    .band2        (band2),
    .band3        (band3),
    .band4        (band4),
    .band5        (band5),
    .band6        (band6),
    .band7        (band7),
    .clear_flags  (clear_flags),
    .energy_valid (energy_valid),
    .energy_ready (energy_ready),
    .energy_band  (energy_band),
    .energy_data  (energy_data),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (energy_valid) saw_valid = 1;
    if (energy_valid && energy_ready) begin
      q_band.push_back(energy_band);
      q_data.push_back(energy_data);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bvec_t all_b(input logic [15:0] x);
    bvec_t r;
    for (int k = 0; k < 8; k++) r[k] = x;
    return r;
  endfunction

  function automatic evec_t all_e(input logic [31:0] x);
    evec_t r;
    for (int k = 0; k < 8; k++) r[k] = x;
    return r;
  endfunction

  task automatic set_bands(input bvec_t v);
    band0 = v[0]; band1 = v[1]; band2 = v[2]; band3 = v[3];
    band4 = v[4]; band5 = v[5]; band6 = v[6]; band7 = v[7];
  endtask

  task automatic send_window(input bvec_t v, input bit alt, input int n, input int gap);
    bvec_t nv;
    for (int k = 0; k < 8; k++) nv[k] = ~v[k] + 16'd1;
    for (int i = 0; i < n; i++) begin
      set_bands((alt && i[0]) ? nv : v);
      sample_valid = 1'b1;
      tick(1);
      sample_valid = 1'b0;
      tick(gap - 1);
    end
  endtask

  task automatic flush();
    q_band.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic collect(input string tag, input evec_t exp, input bit consec);
    int w = 0;
    while (q_band.size() < 8 && w < 200) begin
      tick(1);
      w++;
    end
    check($sformatf("%s_count", tag), q_band.size(), 8);
    for (int k = 0; k < 8 && k < q_band.size(); k++) begin
      check($sformatf("%s_band%0d_idx", tag, k), q_band[k], k);
      check($sformatf("%s_band%0d_data", tag, k), q_data[k], exp[k]);
      if (consec && k > 0)
        check($sformatf("%s_band%0d_cycle", tag, k), q_cyc[k] - q_cyc[k-1], 1);
    end
    flush();
  endtask

  vec_t vecs[5];

  initial begin
    bvec_t tv;
    evec_t te;
    int bad;

    vecs[0].val = '0; vecs[0].val[3] = 16'd1000; vecs[0].alt = 0;
    vecs[0].exp = '0; vecs[0].exp[3] = 32'd1000000;
    vecs[1].val = '0; vecs[1].val[0] = 16'h8000; vecs[1].val[7] = 16'h7FFF; vecs[1].alt = 0;
    vecs[1].exp = '0; vecs[1].exp[0] = 32'h40000000; vecs[1].exp[7] = 32'h3FFF0001;
    vecs[2].val[0] = 16'hFFFB; vecs[2].val[1] = 16'd7;     vecs[2].val[2] = 16'd0;
    vecs[2].val[3] = 16'd300;  vecs[2].val[4] = 16'hFED4; vecs[2].val[5] = 16'd1;
    vecs[2].val[6] = 16'hFFFF; vecs[2].val[7] = 16'd12345; vecs[2].alt = 0;
    vecs[2].exp[0] = 32'd25;    vecs[2].exp[1] = 32'd49;    vecs[2].exp[2] = 32'd0;
    vecs[2].exp[3] = 32'd90000; vecs[2].exp[4] = 32'd90000; vecs[2].exp[5] = 32'd1;
    vecs[2].exp[6] = 32'd1;     vecs[2].exp[7] = 32'd152399025;
    vecs[3].val = all_b(16'd2); vecs[3].alt = 1; vecs[3].exp = all_e(32'd4);
    vecs[4] = vecs[3];

    reset = 1'b0; sample_valid = 1'b0; clear_flags = 1'b0; energy_ready = 1'b1;
    set_bands('0);
    tick(2);
    check("rst_valid", energy_valid, 0);
    check("rst_band", energy_band, 0);
    check("rst_data", energy_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick(2);

    // Reset in the middle of a window and in the middle of accumulation.
    send_window(all_b(16'd5), 0, 30, 16);
    set_bands(all_b(16'd5));
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    tick(2);
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", energy_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    flush();
    saw_valid = 0;
    send_window(all_b(16'd3), 0, 63, 16);
    check("rst_no_early_valid", saw_valid, 0);
    send_window(all_b(16'd3), 0, 1, 16);
    collect("rst_win", all_e(32'd9), 1);

    // Table of full windows with continuous ready.
    for (int v = 0; v < 5; v++) begin
      flush();
      send_window(vecs[v].val, vecs[v].alt, 64, 16);
      collect($sformatf("vec%0d", v), vecs[v].exp, 1);
    end
    check("table_overrun", overrun, 0);

    // Backpressure: hold band 0 stable, then drop a whole window.
    energy_ready = 1'b0;
    flush();
    tv = '0; tv[0] = 16'd10;
    send_window(tv, 0, 64, 16);
    check("bp_valid", energy_valid, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (energy_valid !== 1'b1 || energy_band !== 3'd0 || energy_data !== 32'd100) bad++;
      tick(1);
    end
    check("bp_hold_stable", bad, 0);
    tv[0] = 16'd20;
    send_window(tv, 0, 64, 16);
    check("bp_overrun", overrun, 2'b10);
    check("bp_old_band", energy_band, 0);
    check("bp_old_data", energy_data, 100);
    energy_ready = 1'b1;
    te = '0; te[0] = 32'd100;
    collect("bp_drain", te, 1);
    check("bp_empty", energy_valid, 0);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("bp_clear", overrun, 0);

    // Strobes every 4 clocks: only every third one is accepted.
    flush();
    set_bands(all_b(16'd7));
    for (int i = 0; i < 24; i++) begin
      sample_valid = 1'b1;
      clear_flags = (i == 4);
      tick(1);
      sample_valid = 1'b0;
      clear_flags = 1'b0;
      if (i == 4) check("set_beats_clear", overrun[0], 1);
      tick(3);
    end
    tick(6);
    check("drop_overrun", overrun, 2'b01);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("drop_clear", overrun, 0);
    saw_valid = 0;
    send_window('0, 0, 55, 16);
    check("drop_no_early_valid", saw_valid, 0);
    send_window('0, 0, 1, 16);
    collect("drop_win", all_e(32'd6), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
